// File: rtl/control_scoreboard_decode_pkg.sv
// Shared decode definitions for the pipelined core: instruction type and
// funct codes, ALU operation encodings, control-word bit positions and the
// control-word width as a function of the register-address width.
package mips_ctrl_pkg;

  typedef enum logic [5:0] {
    OP_R  = 6'b000001,
    OP_LW = 6'b000010,
    OP_SW = 6'b000011
  } opcode_e;

  typedef enum logic [5:0] {
    FN_NOP = 6'd31,
    FN_ADD = 6'd32,
    FN_SUB = 6'd34,
    FN_AND = 6'd36,
    FN_OR  = 6'd37,
    FN_MUL = 6'd50
  } funct_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  // Fixed low bits of the control word.
  localparam int unsigned CTRL_ALU_LO  = 0;
  localparam int unsigned CTRL_WB_MEM  = 2;
  localparam int unsigned CTRL_MEM_WR  = 3;
  localparam int unsigned CTRL_MUX_MUL = 4;
  localparam int unsigned CTRL_MUX_B   = 5;
  localparam int unsigned CTRL_DEST_LO = 6;

  // Register fields and write_rf shift with the register-address width.
  function automatic int unsigned ctrl_srcb_lo(input int unsigned ra_w);
    return 6 + ra_w;
  endfunction

  function automatic int unsigned ctrl_srca_lo(input int unsigned ra_w);
    return 6 + 2 * ra_w;
  endfunction

  function automatic int unsigned ctrl_write_rf(input int unsigned ra_w);
    return 6 + 3 * ra_w;
  endfunction

  function automatic int unsigned ctrl_w(input int unsigned ra_w);
    return 1 + 3 * ra_w + 6;
  endfunction

endpackage

// File: rtl/control_scoreboard_decode_if.sv
// Decode-stage bus: instruction input handshake, control-word output
// handshake, writeback retire port and debug/status outputs.
//   slave  : the decode stage (control_scoreboard_decode)
//   master : the surrounding pipeline / testbench
interface control_scoreboard_decode_if
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned RA_W = 5
) ();
  localparam int unsigned CTRL_W = ctrl_w(RA_W);
  localparam int unsigned NREG   = 1 << RA_W;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] ctrl;
  logic              illegal;
  logic              wb_valid;
  logic [RA_W-1:0]   wb_addr;
  logic              stall;
  logic [NREG-1:0]   busy_vec;

  modport slave (
    input  in_valid, instr, out_ready, wb_valid, wb_addr,
    output in_ready, out_valid, ctrl, illegal, stall, busy_vec
  );

  modport master (
    output in_valid, instr, out_ready, wb_valid, wb_addr,
    input  in_ready, out_valid, ctrl, illegal, stall, busy_vec
  );
endinterface

// File: rtl/control_scoreboard_decode_scoreboard.sv
// Per-register busy scoreboard.
//   clk, rst              : clock, async active-high reset
//   set_en_i/set_addr_i   : mark a register pending (new writer issued)
//   clr_en_i/clr_addr_i   : retire a register write
//   q{a,b,d}_addr_i       : query addresses
//   q{a,b,d}_pend_o       : busy bit with a same-cycle retire already removed
//   busy_vec_o            : registered busy bits (bit 0 always 0)
module reg_scoreboard #(
  parameter int unsigned RA_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_en_i,
  input  logic [RA_W-1:0]        set_addr_i,
  input  logic                   clr_en_i,
  input  logic [RA_W-1:0]        clr_addr_i,
  input  logic [RA_W-1:0]        qa_addr_i,
  input  logic [RA_W-1:0]        qb_addr_i,
  input  logic [RA_W-1:0]        qd_addr_i,
  output logic                   qa_pend_o,
  output logic                   qb_pend_o,
  output logic                   qd_pend_o,
  output logic [(1<<RA_W)-1:0]   busy_vec_o
);
  localparam int unsigned NREG = 1 << RA_W;

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] clr_mask, set_mask, pend;

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (clr_en_i) clr_mask[clr_addr_i] = 1'b1;
    if (set_en_i) set_mask[set_addr_i] = 1'b1;
    pend = busy_q & ~clr_mask;
    // Set is applied after clear so a new writer stays pending.
    busy_d    = pend | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign qa_pend_o  = pend[qa_addr_i];
  assign qb_pend_o  = pend[qb_addr_i];
  assign qd_pend_o  = pend[qd_addr_i];
  assign busy_vec_o = busy_q;

endmodule

// File: rtl/control_scoreboard_decode.sv
// Registered decode stage: turns a 32-bit instruction into the packed
// control word, with valid/ready on both sides and a busy scoreboard that
// holds back instructions whose sources or destination await writeback.
//   clk : clock (rising edge)
//   rst : asynchronous active-high reset
//   bus : control_scoreboard_decode_if.slave (in_valid/in_ready/instr,
//         out_valid/out_ready/ctrl/illegal, wb_valid/wb_addr, stall, busy_vec)
module control_scoreboard_decode
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned RA_W = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  control_scoreboard_decode_if.slave   bus
);
  localparam int unsigned CTRL_W = ctrl_w(RA_W);

  logic [31:0]     instr;
  logic [5:0]      op;
  logic [5:0]      fn;
  logic [RA_W-1:0] rs, rt, rd;

  assign instr = bus.instr;
  assign op    = instr[31:26];
  assign fn    = instr[5:0];
  assign rs    = instr[21 +: RA_W];
  assign rt    = instr[16 +: RA_W];
  assign rd    = instr[11 +: RA_W];

  logic unused_instr_bits;
  assign unused_instr_bits = ^instr;

  // Decode
  logic            dec_write, dec_mbi, dec_mul, dec_memwr, dec_wbmem;
  logic            dec_illegal, use_a, use_b, arith;
  logic [RA_W-1:0] dec_a, dec_b, dec_d;
  alu_op_e         dec_alu;
  logic [CTRL_W-1:0] dec_ctrl;

  always_comb begin
    dec_write   = 1'b0;
    dec_mbi     = 1'b0;
    dec_mul     = 1'b0;
    dec_memwr   = 1'b0;
    dec_wbmem   = 1'b0;
    dec_illegal = 1'b0;
    use_a       = 1'b0;
    use_b       = 1'b0;
    arith       = 1'b0;
    dec_a       = '0;
    dec_b       = '0;
    dec_d       = '0;
    dec_alu     = ALU_ADD;
    case (op)
      OP_R: begin
        case (fn)
          FN_ADD: begin arith = 1'b1; dec_alu = ALU_ADD; end
          FN_SUB: begin arith = 1'b1; dec_alu = ALU_SUB; end
          FN_AND: begin arith = 1'b1; dec_alu = ALU_AND; end
          FN_OR:  begin arith = 1'b1; dec_alu = ALU_OR;  end
          FN_MUL: begin arith = 1'b1; dec_mul = 1'b1;    end
          FN_NOP: ;
          default: dec_illegal = 1'b1;
        endcase
        if (arith) begin
          dec_write = 1'b1;
          dec_a     = rs;
          dec_b     = rt;
          dec_d     = rd;
          dec_mbi   = 1'b1;
          use_a     = 1'b1;
          use_b     = 1'b1;
        end
      end
      OP_LW: begin
        dec_write = 1'b1;
        dec_a     = rs;
        dec_d     = rt;
        dec_wbmem = 1'b1;
        use_a     = 1'b1;
      end
      OP_SW: begin
        dec_a     = rs;
        dec_b     = rt;
        dec_memwr = 1'b1;
        use_a     = 1'b1;
        use_b     = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    dec_ctrl = '0;
    dec_ctrl[ctrl_write_rf(RA_W)]        = dec_write;
    dec_ctrl[ctrl_srca_lo(RA_W) +: RA_W] = dec_a;
    dec_ctrl[ctrl_srcb_lo(RA_W) +: RA_W] = dec_b;
    dec_ctrl[CTRL_DEST_LO +: RA_W]       = dec_d;
    dec_ctrl[CTRL_MUX_B]                 = dec_mbi;
    dec_ctrl[CTRL_MUX_MUL]               = dec_mul;
    dec_ctrl[CTRL_MEM_WR]                = dec_memwr;
    dec_ctrl[CTRL_WB_MEM]                = dec_wbmem;
    dec_ctrl[CTRL_ALU_LO +: 2]           = dec_alu;
  end

  // Hazard detection and issue
  logic pend_a, pend_b, pend_d, hazard, issue, set_en;
  logic out_valid_q, out_valid_d;
  logic illegal_q, illegal_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  assign hazard = (use_a & pend_a) | (use_b & pend_b) | (dec_write & pend_d);
  assign issue  = bus.in_valid & ~hazard & (~out_valid_q | bus.out_ready);
  assign set_en = issue & dec_write & (dec_d != '0);

  reg_scoreboard #(.RA_W(RA_W)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (set_en),
    .set_addr_i (dec_d),
    .clr_en_i   (bus.wb_valid),
    .clr_addr_i (bus.wb_addr),
    .qa_addr_i  (dec_a),
    .qb_addr_i  (dec_b),
    .qd_addr_i  (dec_d),
    .qa_pend_o  (pend_a),
    .qb_pend_o  (pend_b),
    .qd_pend_o  (pend_d),
    .busy_vec_o (bus.busy_vec)
  );

  // Output register: load on issue, drop valid when consumed, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    illegal_d   = illegal_q;
    if (issue) begin
      out_valid_d = 1'b1;
      ctrl_d      = dec_ctrl;
      illegal_d   = dec_illegal;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.in_ready  = issue;
  assign bus.stall     = bus.in_valid & hazard;
  assign bus.out_valid = out_valid_q;
  assign bus.ctrl      = ctrl_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_control_scoreboard_decode.sv
module tb_control_scoreboard_decode;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  control_scoreboard_decode_if #(.RA_W(5)) bus ();

  control_scoreboard_decode #(.RA_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        iv;
    logic [31:0] ins;
    logic        ordy;
    logic        wbv;
    logic [4:0]  wba;
    logic        e_ready;
    logic        e_stall;
    logic        e_ov;
    logic [21:0] e_ctrl;
    logic        e_ill;
    logic [31:0] e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] r_i(input logic [4:0] rd, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [5:0] f);
    return {6'b000001, rs, rt, rd, 5'd0, f};
  endfunction

  function automatic logic [31:0] m_i(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt);
    return {op, rs, rt, 16'h0000};
  endfunction

  function automatic vec_t v(input string nm, input logic iv, input logic [31:0] ins,
                             input logic ordy, input logic wbv, input logic [4:0] wba,
                             input logic er, input logic es, input logic eov,
                             input logic [21:0] ec, input logic eill, input logic [31:0] eb);
    vec_t t;
    t.name = nm; t.iv = iv; t.ins = ins; t.ordy = ordy; t.wbv = wbv; t.wba = wba;
    t.e_ready = er; t.e_stall = es; t.e_ov = eov; t.e_ctrl = ec; t.e_ill = eill;
    t.e_busy = eb;
    return t;
  endfunction

  task automatic drive(input logic iv, input logic [31:0] ins, input logic ordy,
                       input logic wbv, input logic [4:0] wba);
    bus.in_valid  = iv;
    bus.instr     = ins;
    bus.out_ready = ordy;
    bus.wb_valid  = wbv;
    bus.wb_addr   = wba;
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0);

    //       name          iv  instr                          ordy wbv wba  rdy stl ov  ctrl        ill busy
    vecs.push_back(v("add_r3",     1, 32'h04221AA0,               1, 0, 5'd0,  1, 0, 1, 22'h2110E0, 0, 32'h08));
    vecs.push_back(v("lw_r5",      1, m_i(6'd2, 5'd1, 5'd5),      1, 0, 5'd0,  1, 0, 1, 22'h210144, 0, 32'h28));
    vecs.push_back(v("raw_stall1", 1, r_i(5'd6, 5'd5, 5'd2, 6'd34), 1, 0, 5'd0, 0, 1, 0, 22'h0,     0, 32'h28));
    vecs.push_back(v("raw_stall2", 1, r_i(5'd6, 5'd5, 5'd2, 6'd34), 1, 0, 5'd0, 0, 1, 0, 22'h0,     0, 32'h28));
    vecs.push_back(v("raw_wb",     1, r_i(5'd6, 5'd5, 5'd2, 6'd34), 1, 1, 5'd5, 1, 0, 1, 22'h2511A1, 0, 32'h48));
    vecs.push_back(v("bp_hold1",   1, r_i(5'd7, 5'd1, 5'd2, 6'd36), 0, 0, 5'd0, 0, 0, 1, 22'h2511A1, 0, 32'h48));
    vecs.push_back(v("bp_hold2",   1, r_i(5'd7, 5'd1, 5'd2, 6'd36), 0, 0, 5'd0, 0, 0, 1, 22'h2511A1, 0, 32'h48));
    vecs.push_back(v("bp_release", 1, r_i(5'd7, 5'd1, 5'd2, 6'd36), 1, 0, 5'd0, 1, 0, 1, 22'h2111E2, 0, 32'hC8));
    vecs.push_back(v("mul_r4",     1, r_i(5'd4, 5'd1, 5'd2, 6'd50), 1, 0, 5'd0, 1, 0, 1, 22'h211130, 0, 32'hD8));
    vecs.push_back(v("or_r4_setclr", 1, r_i(5'd4, 5'd1, 5'd2, 6'd37), 1, 1, 5'd4, 1, 0, 1, 22'h211123, 0, 32'hD8));
    vecs.push_back(v("ill_funct33", 1, r_i(5'd9, 5'd1, 5'd2, 6'd33), 1, 0, 5'd0, 1, 0, 1, 22'h0,     1, 32'hD8));
    vecs.push_back(v("ill_type3f", 1, m_i(6'h3F, 5'd1, 5'd9),     1, 1, 5'd10, 1, 0, 1, 22'h0,      1, 32'hD8));
    vecs.push_back(v("sw_stall",   1, m_i(6'd3, 5'd1, 5'd7),      1, 0, 5'd0,  0, 1, 0, 22'h0,      0, 32'hD8));
    vecs.push_back(v("sw_wb7",     1, m_i(6'd3, 5'd1, 5'd7),      1, 1, 5'd7,  1, 0, 1, 22'h013808, 0, 32'h58));
    vecs.push_back(v("nop_busy_fields", 1, r_i(5'd4, 5'd3, 5'd6, 6'd31), 1, 0, 5'd0, 1, 0, 1, 22'h0, 0, 32'h58));
    vecs.push_back(v("waw_stall",  1, r_i(5'd6, 5'd1, 5'd2, 6'd32), 1, 0, 5'd0, 0, 1, 0, 22'h0,     0, 32'h58));
    vecs.push_back(v("idle_wb6",   0, 32'h0,                      1, 1, 5'd6,  0, 0, 0, 22'h0,      0, 32'h18));
    vecs.push_back(v("lw_r0",      1, m_i(6'd2, 5'd1, 5'd0),      1, 0, 5'd0,  1, 0, 1, 22'h210004, 0, 32'h18));

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
    chk("reset_ctrl",      32'(bus.ctrl),      32'h0);
    chk("reset_illegal",   32'(bus.illegal),   32'h0);
    chk("reset_busy",      bus.busy_vec,       32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].ins, vecs[i].ordy, vecs[i].wbv, vecs[i].wba);
      #2;
      chk({vecs[i].name, ".in_ready"}, 32'(bus.in_ready), 32'(vecs[i].e_ready));
      chk({vecs[i].name, ".stall"},    32'(bus.stall),    32'(vecs[i].e_stall));
      @(posedge clk);
      #1;
      chk({vecs[i].name, ".out_valid"}, 32'(bus.out_valid), 32'(vecs[i].e_ov));
      if (vecs[i].e_ov) begin
        chk({vecs[i].name, ".ctrl"},    32'(bus.ctrl),    32'(vecs[i].e_ctrl));
        chk({vecs[i].name, ".illegal"}, 32'(bus.illegal), 32'(vecs[i].e_ill));
      end
      chk({vecs[i].name, ".busy_vec"}, bus.busy_vec, vecs[i].e_busy);
    end

    // Asynchronous reset between edges while a word is held and bits are busy
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
    #3 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("midrst_ctrl",      32'(bus.ctrl),      32'h0);
    chk("midrst_busy",      bus.busy_vec,       32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // r3 was busy before reset; the add must issue without a stall now
    drive(1'b1, 32'h04221AA0, 1'b1, 1'b0, 5'd0);
    #2;
    chk("postrst_in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("postrst_ctrl", 32'(bus.ctrl),     32'h2110E0);
    chk("postrst_busy", bus.busy_vec,      32'h08);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    chk("postrst_drain", 32'(bus.out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_scoreboard_decode.md
# control_scoreboard_decode

Registered, parametrised successor to the combinational control decoder, and the decode stage of the pipelined core. It turns each fetched 32-bit instruction into the packed control word, with a valid/ready handshake on both sides. A per-register busy scoreboard stalls any instruction whose operands or destination are still pending writeback. Register-address width is generic, so the same block serves the 8-, 16- and 32-entry register-file builds.

## Interface
- `RA_W`, default 5: register-address width. The register file has 2^RA_W entries and must satisfy RA_W ≤ 5.
- `CTRL_W`, default 1+3*RA_W+6 (22 when RA_W=5): control-word width. Derived; never overridden.
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `in_valid`, in, 1: `instr` is valid.
- `in_ready`, out, 1: the instruction is accepted this cycle.
- `instr`, in, 32: instruction. Fields: [31:26] type, [25:21] rs, [20:16] rt, [15:11] rd, [5:0] funct. Only the low RA_W bits of each register field are used.
- `out_valid`, out, 1: `ctrl` is valid.
- `out_ready`, in, 1: the execute stage takes `ctrl` this cycle.
- `ctrl`, out, CTRL_W: control word, MSB→LSB: write_rf, srcA, srcB, dest, mux_b_imm (1=B), mux_alu_mul (1=MUL), mem_wr, wb_mem, alu_op[1:0] (00 add, 01 sub, 10 and, 11 or).
- `illegal`, out, 1: sideband qualified by `out_valid`. The current word came from an undefined opcode or funct.
- `wb_valid`, in, 1: the writeback stage retires a register write.
- `wb_addr`, in, RA_W: register being retired.
- `stall`, out, 1: `in_valid` is high but the instruction is held back by a hazard.
- `busy_vec`, out, 2^RA_W: scoreboard state, for debug.

## Operation
- **Decode, type 000001 (R-type):**
  - funct 32 add, 34 sub, 36 and, 37 or: write_rf=1, A=rs, B=rt, D=rd, mux_b_imm=1, alu_op=00/01/10/11 respectively.
  - funct 50 mul: same fields as add, but mux_alu_mul=1 and alu_op=00.
  - funct 31 nop: all fields zero.
- **Decode, type 000010 (lw):** write_rf=1, A=rs, B=0, D=rt, wb_mem=1, all other fields 0.
- **Decode, type 000011 (sw):** write_rf=0, A=rs, B=rt, D=0, mem_wr=1, all other fields 0.
- **Undefined type or funct:** all-zero word with `illegal`=1. Write is disabled; an undefined instruction never writes the register file.
- **Sources used:**
  - R-type arithmetic and mul use A and B.
  - lw uses A.
  - sw uses A and B.
  - nop and illegal use no sources.
- **Hazard:** asserted when any of these pending bits is set:
  - busy[A], if A is used;
  - busy[B], if B is used;
  - busy[D], if write_rf=1 (WAW).
- **Pending bits:** pending = busy & ~(wb_valid ? onehot(wb_addr) : 0). A writeback retiring in the same cycle is therefore seen as already clear.
- **Register 0:** never tracked. busy[0] is constant 0.
- **Issue condition:** issue = in_valid & ~hazard & (~out_valid | out_ready).
  - in_ready = issue.
  - stall = in_valid & hazard.
- **On issue:** the output register loads the decoded word, out_valid is set, and busy[D] is set if write_rf=1 and D≠0.
- **Output handshake:** if out_valid & out_ready with no issue, out_valid clears. If out_valid & ~out_ready, `ctrl` and `illegal` hold stable.
- **Scoreboard update per cycle:** busy_next = (busy & ~clr) | set.
  - When set and clear hit the same register, set wins: the new writer is pending.
  - wb_valid on a non-busy register is ignored.

## Timing
- **Decode latency:** 1 cycle. An instruction accepted in cycle N appears on `ctrl` in cycle N+1.
- **Throughput:** one instruction per cycle when hazard-free and out_ready=1.
- **Reset values:** out_valid=0, ctrl=0, illegal=0, busy_vec=0. in_ready and stall are combinational. Reset mid-operation discards the held word and all pending bits immediately; no writebacks are expected after reset.
- **Dependent-instruction stall:** a hazard stalls an instruction until the cycle in which the matching wb_valid arrives. The instruction issues in that same cycle, with zero bubble after writeback.
- **Combinational paths:** in_ready depends combinationally on out_ready, wb_valid and wb_addr. There is no path from in_valid to out_valid within a cycle.

## Structure
- **Shared package `mips_ctrl_pkg`:**
  - type codes (R=6'b000001, LW=6'b000010, SW=6'b000011);
  - funct codes (31, 32, 34, 36, 37, 50);
  - alu_op encodings;
  - control-word bit positions;
  - CTRL_W as a function of RA_W.
- **Sub-module `reg_scoreboard`:** parametrised by RA_W.
  - Inputs: set_en, set_addr, clr_en, clr_addr, and up to three query addresses.
  - Outputs: the pending bit for each query, and busy_vec.
  - Decode and the output register stay in the top module.

## Test plan
- **Add after reset:** reset, then one add r3=r1+r2 (instr 0x04221A A0), out_ready=1. Expect ctrl=0x2110E0 in the next cycle, illegal=0, and busy_vec bit 3 set.
- **RAW stall:** issue lw r5,(r1), then immediately sub r6=r5-r2. Expect stall=1 and in_ready=0 until wb_valid=1 with wb_addr=5. The sub issues in that same cycle, and afterwards busy bit 5 is clear and bit 6 is set.
- **Output backpressure:** hold out_ready=0 with a word held. Expect ctrl stable and in_ready=0. Release out_ready; the next instruction is accepted in the same cycle.
- **Same-cycle set and clear:** r4 busy. Issue or r4=r1|r2 while wb_valid=1 with wb_addr=4. Expect issue, and busy bit 4 remains 1 afterwards.
- **Undefined encodings:** funct 33, and type 6'b111111. Expect ctrl=0, illegal=1, and busy_vec unchanged. Also issue sw r7,(r1) with r7 busy: expect stall.
- **Reset mid-operation:** with busy bits set and out_valid=1, assert rst asynchronously between clock edges. Expect out_valid, ctrl and busy_vec to go to 0 immediately.
